pad_frame_writer: RTL and testbench

//  Loads a raster pixel stream into the zero-padded frame buffer that the 3x3 window reader scans.

---
 rtl/pad_frame_writer.sv | 164 ++++++++++++++++
 tb/tb_pad_frame_writer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pad_frame_writer.sv
// ---------------------------------------------------------------------------
// pad_frame_writer
//
// Purpose:
//   Loads a raster pixel stream into a zero-padded frame buffer of size
//   (IMG_W+2) x (IMG_H+2). The block writes a one-pixel zero border around
//   the interior pixels, at linear addresses row*(IMG_W+2)+col, in strictly
//   increasing order. The window reader scans this buffer.
//
// Ports:
//   clk        in   1       single clock, posedge
//   rst        in   1       asynchronous active-high reset
//   start      in   1       one-cycle pulse, begins a frame load when idle
//   pix_in     in   DATA_W  input pixel, raster order
//   pix_valid  in   1       pix_in valid
//   pix_ready  out  1       pixel accepted this cycle when pix_valid is also high
//   mem_wr     out  1       frame memory write strobe (registered)
//   mem_addr   out  ADDR_W  frame memory write address (registered)
//   mem_data   out  DATA_W  frame memory write data (registered)
//   busy       out  1       high while a frame load is in progress (FILL/DONE)
//   done       out  1       one-cycle pulse, one cycle after the last write
//   checksum   out  16      only with WR_CHECKSUM_EN: sum of accepted pixels
//
// Build option:
//   WR_CHECKSUM_EN - adds the checksum port and its accumulator.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module pad_frame_writer #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 256,
    parameter int IMG_H  = 32,
    parameter int ADDR_W = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              done
`ifdef WR_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam int ROW_W = $clog2(IMG_H + 3);
    localparam int COL_W = $clog2(IMG_W + 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H + 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [ROW_W-1:0]  row_reg;
    logic [COL_W-1:0]  col_reg;
    logic [ADDR_W-1:0] addr_reg;      // running linear address of the current position
    logic              mem_wr_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic [DATA_W-1:0] mem_data_reg;
    logic              done_reg;

    logic border;
    logic last_pos;
    logic in_fill;
    logic advance;
    logic accept_start;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and position decode
    always_comb begin
        state_next   = state_reg;
        border       = (row_reg == '0) || (row_reg == ROW_LAST) ||
                       (col_reg == '0) || (col_reg == COL_LAST);
        last_pos     = (row_reg == ROW_LAST) && (col_reg == COL_LAST);
        in_fill      = (state_reg == FILL);
        accept_start = (state_reg == IDLE) && start;
        // Ready depends only on where we are, never on pix_valid, so the
        // source sees a clean handshake.
        pix_ready    = in_fill && !border;
        // Border positions advance unconditionally; interior ones wait for data.
        advance      = in_fill && (border || pix_valid);

        case (state_reg)
            IDLE:    if (start) state_next = FILL;
            FILL:    if (advance && last_pos) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Position counters and registered write port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_reg      <= '0;
            col_reg      <= '0;
            addr_reg     <= '0;
            mem_wr_reg   <= 1'b0;
            mem_addr_reg <= '0;
            mem_data_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            mem_wr_reg <= advance;
            done_reg   <= (state_reg == DONE);
            if (accept_start) begin
                row_reg  <= '0;
                col_reg  <= '0;
                addr_reg <= '0;
            end else if (advance) begin
                mem_addr_reg <= addr_reg;
                mem_data_reg <= border ? '0 : pix_in;
                // Address tracks row*(IMG_W+2)+col incrementally, one step per write.
                addr_reg     <= addr_reg + ADDR_W'(1);
                if (col_reg == COL_LAST) begin
                    col_reg <= '0;
                    row_reg <= row_reg + ROW_W'(1);
                end else begin
                    col_reg <= col_reg + COL_W'(1);
                end
            end
        end
    end

    assign mem_wr   = mem_wr_reg;
    assign mem_addr = mem_addr_reg;
    assign mem_data = mem_data_reg;
    assign done     = done_reg;
    assign busy     = (state_reg != IDLE);

`ifdef WR_CHECKSUM_EN
    logic [15:0] checksum_reg;

    // Sums only accepted interior pixels; border zeros never reach it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum_reg <= '0;
        end else if (accept_start) begin
            checksum_reg <= '0;
        end else if (pix_ready && pix_valid) begin
            checksum_reg <= checksum_reg + 16'(pix_in);
        end
    end

    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_pad_frame_writer.sv
`timescale 1ns/1ps
module tb_pad_frame_writer;

    localparam int DATA_W = 8;
    localparam int IMG_W  = 256;
    localparam int IMG_H  = 32;
    localparam int ADDR_W = 15;
    localparam int W2     = IMG_W + 2;
    localparam int H2     = IMG_H + 2;
    localparam int TOTAL  = W2 * H2;

    typedef enum int {M_IDLE, M_FILL, M_DONE} mstate_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [DATA_W-1:0] pix_in;
    logic              pix_valid;
    logic              pix_ready;
    logic              mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              busy;
    logic              done;
`ifdef WR_CHECKSUM_EN
    logic [15:0]       checksum;
`endif

    pad_frame_writer #(
        .DATA_W(DATA_W), .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pix_in(pix_in),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .mem_wr(mem_wr),
        .mem_addr(mem_addr), .mem_data(mem_data), .busy(busy), .done(done)
`ifdef WR_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Source pixels still to be delivered, and the expected write stream.
    logic [DATA_W-1:0] src_q[$];
    int                exp_addr_q[$];
    logic [DATA_W-1:0] exp_data_q[$];
    logic [15:0]       exp_sum;

    // Reference model of position/state
    mstate_t m_state, m_state_n;
    int      pos, pos_n;
    bit      adv, adv_prev, xfer, was_done, was_done_n;
    int      last_wr_addr;
    int      wr_cnt, done_seen;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    function automatic bit interior(input int p);
        int r, c;
        r = p / W2;
        c = p % W2;
        return (r != 0) && (r != H2 - 1) && (c != 0) && (c != W2 - 1);
    endfunction

    task automatic reset_model();
        m_state = M_IDLE; m_state_n = M_IDLE;
        pos = 0; pos_n = 0;
        adv = 0; adv_prev = 0; xfer = 0;
        was_done = 0; was_done_n = 0;
        last_wr_addr = 0;
        src_q.delete(); exp_addr_q.delete(); exp_data_q.delete();
    endtask

    // Build source pixels and the expected write stream for one frame.
    task automatic load_frame(input int pat);
        logic [DATA_W-1:0] px;
        exp_sum = '0;
        for (int a = 0; a < TOTAL; a++) begin
            exp_addr_q.push_back(a);
            if (interior(a)) begin
                case (pat)
                    0:       px = DATA_W'((a % W2) - 1);
                    1:       px = DATA_W'($urandom);
                    default: px = '1;
                endcase
                src_q.push_back(px);
                exp_data_q.push_back(px);
                exp_sum = exp_sum + 16'(px);
            end else begin
                exp_data_q.push_back('0);
            end
        end
    endtask

    // Posedge side: commit the model step decided in the previous cycle.
    task automatic tick_a();
        @(posedge clk);
        #1;
        if (xfer) void'(src_q.pop_front());
        m_state  = m_state_n;
        pos      = pos_n;
        adv_prev = adv;
        was_done = was_done_n;
    endtask

    // Negedge side: compare DUT outputs against the model, then step the model.
    task automatic tick_b();
        int               ea;
        logic [DATA_W-1:0] ed;
        @(negedge clk);
        check("pix_ready", 32'(pix_ready), 32'(m_state == M_FILL && interior(pos)));
        check("busy", 32'(busy), 32'(m_state != M_IDLE));
        check("mem_wr", 32'(mem_wr), 32'(adv_prev));
        check("done", 32'(done), 32'(was_done));
        if (mem_wr) begin
            wr_cnt++;
            if (exp_addr_q.size() == 0) begin
                check("wr_extra", 32'(mem_addr), 32'hFFFF_FFFF);
            end else begin
                ea = exp_addr_q.pop_front();
                ed = exp_data_q.pop_front();
                check("wr_addr", 32'(mem_addr), 32'(ea));
                check("wr_data", 32'(mem_data), 32'(ed));
                $display("write addr=%0d data=0x%0h", mem_addr, mem_data);
            end
            last_wr_addr = int'(mem_addr);
        end else begin
            check("addr_hold", 32'(mem_addr), 32'(last_wr_addr));
        end
        if (done) begin
            done_seen++;
`ifdef WR_CHECKSUM_EN
            check("checksum", 32'(checksum), 32'(exp_sum));
`endif
        end

        adv = 0; xfer = 0;
        m_state_n = m_state; pos_n = pos;
        was_done_n = (m_state == M_DONE);
        case (m_state)
            M_IDLE: if (start) begin m_state_n = M_FILL; pos_n = 0; end
            M_FILL: begin
                adv  = !interior(pos) || pix_valid;
                xfer = interior(pos) && pix_valid;
                if (adv) begin
                    pos_n = pos + 1;
                    if (pos == TOTAL - 1) m_state_n = M_DONE;
                end
            end
            default: m_state_n = M_IDLE;
        endcase
    endtask

    task automatic do_abort();
        #1 rst = 1'b1;
        #1;
        check("abort_mem_wr", 32'(mem_wr), 32'd0);
        check("abort_mem_addr", 32'(mem_addr), 32'd0);
        check("abort_mem_data", 32'(mem_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_pix_ready", 32'(pix_ready), 32'd0);
`ifdef WR_CHECKSUM_EN
        check("abort_checksum", 32'(checksum), 32'd0);
`endif
        start = 1'b0; pix_valid = 1'b0;
        reset_model();
        #1 rst = 1'b0;
    endtask

    // One frame load. stall_mode 0: continuous valid; 1: 5-cycle drop at
    // position 268 plus random gaps. mid_start_pos/done_start inject ignored
    // start pulses; abort_pos >= 0 hits reset at that position.
    task automatic run_frame(input int pat, input int stall_mode, input int mid_start_pos,
                             input bit done_start, input int abort_pos);
        bit started, seen_done, finished;
        int idle_after, drop_cnt;
        started = 0; seen_done = 0; finished = 0; idle_after = 0; drop_cnt = 0;
        wr_cnt = 0; done_seen = 0;
        load_frame(pat);
        for (int n = 0; n < 20000 && !finished; n++) begin
            tick_a();
            if (abort_pos >= 0 && m_state == M_FILL && pos == abort_pos) begin
                do_abort();
                return;
            end
            if (m_state == M_DONE) seen_done = 1;
            if (seen_done && m_state == M_IDLE) begin
                idle_after++;
                if (idle_after >= 4) finished = 1;
            end
            start = 1'b0;
            if (m_state == M_IDLE && !started) begin
                start = 1'b1; started = 1;
            end else if (m_state == M_FILL && pos == mid_start_pos) begin
                start = 1'b1;
            end else if (m_state == M_DONE && done_start) begin
                start = 1'b1;
            end
            if (src_q.size() == 0) begin
                pix_valid = 1'b0;
            end else if (stall_mode == 0) begin
                pix_valid = 1'b1;
            end else if (m_state == M_FILL && pos == 268 && drop_cnt < 5) begin
                pix_valid = 1'b0;
                drop_cnt++;
            end else begin
                pix_valid = ($urandom_range(3) != 0);
            end
            pix_in = pix_valid ? src_q[0] : DATA_W'($urandom);
            tick_b();
        end
        start = 1'b0; pix_valid = 1'b0;
        if (!finished) begin
            check("frame_timeout", 32'd0, 32'd1);
        end else begin
            check("frame_writes", 32'(wr_cnt), 32'(TOTAL));
            check("done_count", 32'(done_seen), 32'd1);
            check("sb_empty", 32'(exp_addr_q.size()), 32'd0);
            check("src_empty", 32'(src_q.size()), 32'd0);
        end
        $display("frame pattern=%0d stall=%0d writes=%0d done_pulses=%0d", pat, stall_mode, wr_cnt, done_seen);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_in = '0;
        reset_model();
        wr_cnt = 0; done_seen = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_pix_ready", 32'(pix_ready), 32'd0);
        check("rst_mem_wr", 32'(mem_wr), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_data", 32'(mem_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
`ifdef WR_CHECKSUM_EN
        check("rst_checksum", 32'(checksum), 32'd0);
`endif
        rst = 1'b0;

        run_frame(0, 0, 3000, 1'b1, -1);   // continuous, ignored starts
        run_frame(1, 1, -1, 1'b0, -1);     // stalls and border-held pixels
        run_frame(1, 0, -1, 1'b0, 4000);   // reset mid-frame
        for (int i = 0; i < 3; i++) begin
            tick_a();
            tick_b();
        end
        run_frame(2, 0, -1, 1'b0, -1);     // all 0xFF, reload from address 0

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
